multi_start_stop_timer: RTL and testbench
=========================================

Name: multi_start_stop_timer

Overview:
Multi-channel successor to the single start/stop pause timer used on the CNC control path. Each channel watches an asynchronous control signal. On a qualifying edge, it asserts a pause window whose length depends on the edge direction: a start length for rising edges, a stop length for falling edges. Features beyond the single-channel timer: per-channel edge-mode select, a retrigger option, and a one-cycle expiry pulse. Windows are exact and restart-aligned. pause_any feeds the motion sequencer's hold input.

Parameters:
CHANNELS, 4, number of independent timer channels
PRE_WIDTH, 16, prescaler width; tick period = scale+1 clocks
WIDTH, 16, length counter width
SYNC_STAGES, 2, input synchronizer depth (>=2)

Ports:
clk  in  1  system clock
aclr_n  in  1  asynchronous active-low reset
sclr  in  1  synchronous clear, active high
scale  in  PRE_WIDTH  prescaler terminal value, shared by all channels
sig  in  CHANNELS  asynchronous control inputs
mode  in  2*CHANNELS  per channel: 00 off, 01 rise, 10 fall, 11 both
retrig  in  CHANNELS  1 = a qualifying edge during pause reloads the window
start_len  in  WIDTH*CHANNELS  window after a rising edge, in ticks minus 1
stop_len  in  WIDTH*CHANNELS  window after a falling edge, in ticks minus 1
pause  out  CHANNELS  window active
pause_any  out  1  OR of pause, registered
done  out  CHANNELS  one-cycle pulse at window expiry

Behaviour:
- Reset (aclr_n=0): pause, pause_any, done, all counters and all synchronizer/edge registers go to 0.
- sclr=1: same state as reset, applied on the clock edge. The edge register then loads the current synced value, so no edge fires on sclr release.
- Synchronizer: SYNC_STAGES flops, followed by a previous-value register.
- After aclr_n release, sig held high is seen as a rising edge; this is decided.
- Latency: with default SYNC_STAGES, pause rises on the 3rd rising clk edge after sig changes (setup met).
- Qualifying edge:
  - rise when mode[0]=1; fall when mode[1]=1.
  - mode=00 forces pause=0 and idles the channel from the next cycle, including mid-window.
- Trigger, when idle:
  - Load the length counter with start_len (rise) or stop_len (fall), sampled at the trigger cycle.
  - Clear the channel prescaler to 0.
  - Set pause=1.
- Per-channel prescaler:
  - Counts 0..scale while pause=1; tick when count==scale, then wraps to 0.
  - scale=0 gives a tick every clock.
- On a tick:
  - If the counter is 0, clear pause and pulse done for one cycle.
  - Otherwise decrement the counter.
- Window length is exactly (len+1)*(scale+1) clocks of pause=1.
- Edge while pause=1:
  - retrig=1: reload the counter with the length for that edge's direction and clear the prescaler; done does not pulse.
  - retrig=0: edge ignored.
- Edge in the same cycle as expiry: with retrig=1, the reload wins; pause stays 1 and done does not pulse. With retrig=0, the window expires and the edge is dropped.
- scale changes mid-window take effect immediately, on the next compare. The length inputs are only sampled at trigger or reload.
- pause_any is the registered OR of the next-state pause values, so it is cycle-aligned with pause.
- Counters never wrap: decrement happens only when the counter is nonzero.

Decomposition:
- Package ss_timer_pkg:
  - typedef enum logic [1:0] ss_mode_t {SS_OFF, SS_RISE, SS_FALL, SS_BOTH}.
  - Channel state enum {CH_IDLE, CH_PAUSE}.
- Sub-module start_stop_channel holds one synchronizer, edge detector, prescaler, length counter and FSM.
- The top level contains only a generate loop, port slicing and pause_any.

Test Plan:
- Window length: scale=9, start_len=4, mode=01, sig 0->1 -> pause high for exactly 50 clocks, rising 3 clocks after the sig change; one done pulse at the falling edge of pause.
- Direction-dependent length: mode=11, start_len=4, stop_len=1, sig 0->1, then 0 after 200 clocks -> two windows of 50 and 20 clocks.
- Retrigger on: retrig=1, scale=9, len=4, second rise 30 clocks into the window -> pause continuous for 80 clocks total, exactly one done.
- Retrigger off: same stimulus with retrig=0 -> 50-clock window; the second edge is ignored and no new window follows.
- Channel independence and pause_any: ch0 scale=0, len=0 (1 clock); ch1 len=9 -> pause_any equals pause[0]|pause[1] every cycle.
- Reset and clear: aclr_n pulsed low mid-window -> pause=0 immediately. sclr pulsed with sig high -> no window after release. mode set to 00 mid-window -> pause=0 next cycle and no done pulse.

Source files
------------

// File: rtl/ss_timer_pkg.sv
// Shared types for the start/stop pause timer channels.
package ss_timer_pkg;

    typedef enum logic [1:0] {
        SS_OFF  = 2'b00,
        SS_RISE = 2'b01,
        SS_FALL = 2'b10,
        SS_BOTH = 2'b11
    } ss_mode_t;

    typedef enum logic {
        CH_IDLE,
        CH_PAUSE
    } ch_state_t;

    function automatic logic mode_rise(input ss_mode_t m);
        return m[0];
    endfunction

    function automatic logic mode_fall(input ss_mode_t m);
        return m[1];
    endfunction

endpackage

// File: rtl/start_stop_channel.sv
// One pause-timer channel: synchronizer, edge detect, prescaler, length counter
// and window FSM.
module start_stop_channel
    import ss_timer_pkg::*;
#(
    parameter int PRE_WIDTH   = 16,
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 aclr_n,
    input  logic                 sclr,
    input  logic [PRE_WIDTH-1:0] scale,
    input  logic                 sig,
    input  logic [1:0]           mode,
    input  logic                 retrig,
    input  logic [WIDTH-1:0]     start_len,
    input  logic [WIDTH-1:0]     stop_len,
    output logic                 pause,
    output logic                 pause_nxt,
    output logic                 done
);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   prev_p1;
    logic                   synced;
    ss_mode_t               md;
    logic                   rise, fall, trig, tick;
    logic [WIDTH-1:0]       len_sel;

    ch_state_t              state, state_n;
    logic [WIDTH-1:0]       cnt, cnt_n;
    logic [PRE_WIDTH-1:0]   pre, pre_n;
    logic                   pause_n, done_n;

    // Synchronizer keeps sampling through sclr so the edge register tracks sig
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            sync_p0 <= '0;
            prev_p1 <= 1'b0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], sig};
            prev_p1 <= synced;
        end
    end

    assign synced  = sync_p0[SYNC_STAGES-1];
    assign md      = ss_mode_t'(mode);
    assign rise    = synced & ~prev_p1 & mode_rise(md);
    assign fall    = ~synced & prev_p1 & mode_fall(md);
    assign trig    = rise | fall;
    assign len_sel = rise ? start_len : stop_len;
    // >= keeps ticking sane if scale is lowered below the running count
    assign tick    = (pre >= scale);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pre_n   = pre;
        pause_n = pause;
        done_n  = 1'b0;
        if (sclr || md == SS_OFF) begin
            state_n = CH_IDLE;
            cnt_n   = '0;
            pre_n   = '0;
            pause_n = 1'b0;
        end else begin
            case (state)
                CH_IDLE: begin
                    if (trig) begin
                        state_n = CH_PAUSE;
                        cnt_n   = len_sel;
                        pre_n   = '0;
                        pause_n = 1'b1;
                    end
                end
                CH_PAUSE: begin
                    if (trig && retrig) begin
                        cnt_n = len_sel;
                        pre_n = '0;
                    end else if (tick) begin
                        pre_n = '0;
                        if (cnt == '0) begin
                            state_n = CH_IDLE;
                            pause_n = 1'b0;
                            done_n  = 1'b1;
                        end else begin
                            cnt_n = cnt - 1'b1;
                        end
                    end else begin
                        pre_n = pre + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state <= CH_IDLE;
            cnt   <= '0;
            pre   <= '0;
            pause <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pre   <= pre_n;
            pause <= pause_n;
            done  <= done_n;
        end
    end

    assign pause_nxt = pause_n;

endmodule

// File: rtl/multi_start_stop_timer.sv
// Multi-channel start/stop pause timer; pause_any drives the sequencer hold.
module multi_start_stop_timer
    import ss_timer_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int PRE_WIDTH   = 16,
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      aclr_n,
    input  logic                      sclr,
    input  logic [PRE_WIDTH-1:0]      scale,
    input  logic [CHANNELS-1:0]       sig,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [CHANNELS-1:0]       retrig,
    input  logic [WIDTH*CHANNELS-1:0] start_len,
    input  logic [WIDTH*CHANNELS-1:0] stop_len,
    output logic [CHANNELS-1:0]       pause,
    output logic                      pause_any,
    output logic [CHANNELS-1:0]       done
);

    logic [CHANNELS-1:0] pause_nxt;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        start_stop_channel #(
            .PRE_WIDTH  (PRE_WIDTH),
            .WIDTH      (WIDTH),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_ch (
            .clk      (clk),
            .aclr_n   (aclr_n),
            .sclr     (sclr),
            .scale    (scale),
            .sig      (sig[g]),
            .mode     (mode[2*g +: 2]),
            .retrig   (retrig[g]),
            .start_len(start_len[WIDTH*g +: WIDTH]),
            .stop_len (stop_len[WIDTH*g +: WIDTH]),
            .pause    (pause[g]),
            .pause_nxt(pause_nxt[g]),
            .done     (done[g])
        );
    end

    // Registered from next-state values so it lines up with pause
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            pause_any <= 1'b0;
        end else begin
            pause_any <= |pause_nxt;
        end
    end

endmodule

// File: tb/tb_multi_start_stop_timer.sv
// Randomized and directed bench for multi_start_stop_timer against a
// clock-count window model.
module tb_multi_start_stop_timer;

    localparam int CH   = 4;
    localparam int PW   = 16;
    localparam int W    = 16;
    localparam int SYNC = 2;

    logic              clk = 1'b0;
    logic              aclr_n;
    logic              sclr;
    logic [PW-1:0]     scale;
    logic [CH-1:0]     sig;
    logic [2*CH-1:0]   mode;
    logic [CH-1:0]     retrig;
    logic [W*CH-1:0]   start_len;
    logic [W*CH-1:0]   stop_len;
    logic [CH-1:0]     pause;
    logic              pause_any;
    logic [CH-1:0]     done;

    int n_checks = 0;
    int n_errors = 0;

    multi_start_stop_timer #(
        .CHANNELS(CH), .PRE_WIDTH(PW), .WIDTH(W), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .scale(scale), .sig(sig),
        .mode(mode), .retrig(retrig), .start_len(start_len), .stop_len(stop_len),
        .pause(pause), .pause_any(pause_any), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each window is a count of remaining pause clocks
    logic [SYNC-1:0] m_hist [CH];
    bit              m_prev [CH];
    bit              m_act  [CH];
    bit              m_done [CH];
    longint          m_rem  [CH];
    bit              m_syn, m_rise, m_fall;
    longint          m_full;

    always @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            for (int c = 0; c < CH; c++) begin
                m_hist[c] = '0; m_prev[c] = 0; m_act[c] = 0; m_done[c] = 0; m_rem[c] = 0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                m_syn  = m_hist[c][SYNC-1];
                m_rise = m_syn && !m_prev[c] && mode[2*c];
                m_fall = !m_syn && m_prev[c] && mode[2*c+1];
                m_full = (longint'(m_rise ? start_len[c*W +: W] : stop_len[c*W +: W]) + 1)
                         * (longint'(scale) + 1);
                m_done[c] = 0;
                if (sclr || mode[2*c +: 2] == 2'b00) begin
                    m_act[c] = 0;
                end else if (!m_act[c]) begin
                    if (m_rise || m_fall) begin
                        m_act[c] = 1;
                        m_rem[c] = m_full;
                    end
                end else if ((m_rise || m_fall) && retrig[c]) begin
                    m_rem[c] = m_full;
                end else begin
                    m_rem[c]--;
                    if (m_rem[c] == 0) begin
                        m_act[c]  = 0;
                        m_done[c] = 1;
                    end
                end
                m_prev[c] = m_syn;
                m_hist[c] = {m_hist[c][SYNC-2:0], sig[c]};
            end
        end
    end

    logic [CH-1:0] exp_pause, exp_done;

    always @(negedge clk) begin
        for (int c = 0; c < CH; c++) begin
            exp_pause[c] = m_act[c];
            exp_done[c]  = m_done[c];
        end
        chk("pause", pause, exp_pause);
        chk("done", done, exp_done);
        chk("pause_any", pause_any, |exp_pause);
    end

    // Channel 0 window log: lengths of completed windows and done pulses
    int win_q[$];
    int run    = 0;
    int ndone0 = 0;

    always @(negedge clk) begin
        if (pause[0] === 1'b1) run++;
        else if (run > 0) begin
            win_q.push_back(run);
            run = 0;
        end
        if (done[0] === 1'b1) ndone0++;
    end

    function automatic int win_at(input int i);
        return (i < win_q.size()) ? win_q[i] : -1;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ch(input int c, input logic [1:0] m, input logic rt,
                          input int sl, input int pl);
        mode[2*c +: 2]      = m;
        retrig[c]           = rt;
        start_len[c*W +: W] = W'(sl);
        stop_len[c*W +: W]  = W'(pl);
    endtask

    int w0, d0;

    initial begin
        aclr_n = 1'b0; sclr = 1'b0; scale = '0; sig = '0;
        mode = '0; retrig = '0; start_len = '0; stop_len = '0;
        idle(3);
        chk("rst_pause", pause, 0);
        chk("rst_pause_any", pause_any, 0);
        chk("rst_done", done, 0);
        aclr_n = 1'b1;
        idle(3);

        // Basic window and input latency
        scale = 9;
        set_ch(0, 2'b01, 1'b0, 4, 0);
        w0 = win_q.size(); d0 = ndone0;
        sig[0] = 1'b1;
        @(negedge clk); chk("lat_e1", pause[0], 0);
        @(negedge clk); chk("lat_e2", pause[0], 0);
        @(negedge clk); chk("lat_e3", pause[0], 1);
        idle(80);
        chk("w1_count", win_q.size() - w0, 1);
        chk("w1_len", win_at(w0), 50);
        chk("w1_done", ndone0 - d0, 1);
        sig[0] = 1'b0;
        idle(10);

        // Direction-dependent lengths
        set_ch(0, 2'b11, 1'b0, 4, 1);
        w0 = win_q.size(); d0 = ndone0;
        sig[0] = 1'b1; idle(200);
        sig[0] = 1'b0; idle(100);
        chk("dir_count", win_q.size() - w0, 2);
        chk("dir_rise_len", win_at(w0), 50);
        chk("dir_fall_len", win_at(w0 + 1), 20);
        chk("dir_done", ndone0 - d0, 2);

        // Retrigger on, then off, with a second rise 30 clocks into the window
        for (int rt = 1; rt >= 0; rt--) begin
            set_ch(0, 2'b01, rt[0], 4, 0);
            w0 = win_q.size(); d0 = ndone0;
            sig[0] = 1'b1; idle(10);
            sig[0] = 1'b0; idle(20);
            sig[0] = 1'b1; idle(150);
            chk(rt ? "retrig_count" : "noretrig_count", win_q.size() - w0, 1);
            chk(rt ? "retrig_len" : "noretrig_len", win_at(w0), rt ? 80 : 50);
            chk(rt ? "retrig_done" : "noretrig_done", ndone0 - d0, 1);
            sig[0] = 1'b0; idle(10);
        end

        // Two channels with very different windows; shortest possible window
        scale = 0;
        set_ch(0, 2'b01, 1'b0, 0, 0);
        set_ch(1, 2'b01, 1'b0, 9, 0);
        w0 = win_q.size();
        sig[1:0] = 2'b11; idle(20);
        chk("min_len", win_at(w0), 1);
        sig[1:0] = 2'b00; idle(5);
        set_ch(1, 2'b00, 1'b0, 0, 0);

        // Async reset mid-window
        scale = 9;
        set_ch(0, 2'b01, 1'b0, 4, 0);
        sig[0] = 1'b1; idle(20);
        #2 aclr_n = 1'b0;
        #1 chk("aclr_pause", pause, 0);
        chk("aclr_pause_any", pause_any, 0);
        @(negedge clk); aclr_n = 1'b1;
        idle(80);
        sig[0] = 1'b0; idle(10);

        // Sync clear swallows an edge
        sclr = 1'b1; sig[0] = 1'b1; idle(5);
        sclr = 1'b0;
        w0 = win_q.size();
        idle(80);
        chk("sclr_no_win", win_q.size() - w0, 0);
        sig[0] = 1'b0; idle(5);

        // Mode off mid-window
        d0 = ndone0;
        sig[0] = 1'b1; idle(20);
        mode[1:0] = 2'b00;
        @(negedge clk); chk("off_pause", pause[0], 0);
        idle(60);
        chk("off_no_done", ndone0 - d0, 0);
        sig[0] = 1'b0; idle(5);

        // Randomized phases, scale fixed within a phase
        for (int ph = 0; ph < 6; ph++) begin
            sclr = 1'b1;
            scale = PW'($urandom_range(0, 3));
            for (int c = 0; c < CH; c++)
                set_ch(c, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 7), $urandom_range(0, 7));
            idle(3);
            sclr = 1'b0;
            for (int t = 0; t < 400; t++) begin
                @(negedge clk);
                for (int c = 0; c < CH; c++) begin
                    if ($urandom_range(0, 5) == 0) sig[c] = ~sig[c];
                    if ($urandom_range(0, 19) == 0) start_len[c*W +: W] = W'($urandom_range(0, 7));
                    if ($urandom_range(0, 19) == 0) stop_len[c*W +: W] = W'($urandom_range(0, 7));
                    if ($urandom_range(0, 39) == 0) retrig[c] = ~retrig[c];
                    if ($urandom_range(0, 59) == 0) mode[2*c +: 2] = 2'($urandom_range(0, 3));
                end
                if ($urandom_range(0, 149) == 0) sclr = 1'b1;
                else sclr = 1'b0;
            end
        end
        sclr = 1'b0;
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
